usb_rx_byte_fifo: RTL and testbench
===================================

# usb_rx_byte_fifo

Byte-granular receive FIFO directly downstream of the USB receiver. It accepts 32-bit data words written by the receiver (four bytes per write) and hands bytes one at a time to the host-side reader. It reports byte occupancy back upstream for the receiver's buffer-full and overrun checks, and supports flush (from the receiver) and clear (from the host).

## Interface
Parameters:
- DEPTH, 64, capacity in bytes; power of two, ≥ 8, multiple of 4
- OCC_W, $clog2(DEPTH)+1, occupancy width (derived; not overridden)

Ports:
- clk  in  1  system clock; all logic rising-edge
- rst  in  1  reset, synchronous, active-high
- w_enable  in  1  write one 4-byte word from rcv_data
- rcv_data  in  32  write word; byte 0 = [7:0] is the oldest byte and is read first, byte 3 = [31:24]
- flush  in  1  receiver flush; empties FIFO
- clear  in  1  host clear; empties FIFO and clears error flags
- rd_en  in  1  pop one byte
- rd_data  out  8  byte popped by the last accepted rd_en
- rd_valid  out  1  one-cycle pulse: rd_data updated this cycle
- buffer_occupancy  out  OCC_W  stored byte count, 0..DEPTH
- full  out  1  buffer_occupancy == DEPTH
- empty  out  1  buffer_occupancy == 0
- overflow  out  1  sticky: write rejected for lack of space
- underflow  out  1  sticky: read attempted while empty

## Operation
- Storage: DEPTH×8 register array; 6-bit (log2 DEPTH) wr_ptr and rd_ptr, both wrapping modulo DEPTH; OCC_W-bit occ counter.
- wr_ptr only moves in steps of 4 from 0, so it is always word-aligned. A write fills mem[wr_ptr+0..3] with bytes 0..3.
- Write accept: w_enable && (DEPTH − occ) ≥ 4, evaluated on pre-cycle occ. A same-cycle read does not create room.
- Rejected write: nothing stored; overflow ← 1.
- Read accept: rd_en && occ ≠ 0, evaluated on pre-cycle occ. An empty FIFO cannot be read through by a same-cycle write.
  - On accept: rd_data ← mem[rd_ptr], rd_ptr+1, rd_valid ← 1.
  - When empty: rd_data holds, rd_valid ← 0, underflow ← 1.
- Occupancy update: occ_next = occ + 4·wr_acc − rd_acc. Simultaneous write and read gives +3.
- Priority, highest first: rst > clear > flush > read/write.
  - clear: ptrs, occ ← 0, overflow and underflow ← 0, rd_valid ← 0; rd_data holds.
  - flush: ptrs, occ ← 0, rd_valid ← 0; error flags hold; concurrent w_enable/rd_en ignored.
- No state machine: the block is a pointer/counter datapath only.

## Timing
- Reset values: rd_data 8'h00, rd_valid 0, buffer_occupancy 0, full 0, empty 1, overflow 0, underflow 0, ptrs 0. Memory contents are not reset.
- All outputs are registered or decoded from registered occ. Occupancy reflects a write or read one cycle after the accepting edge.
- Read latency: rd_en sampled at edge N → rd_data/rd_valid valid after edge N; one byte per cycle sustained.
- Write throughput: one word per cycle while space ≥ 4.
- full/empty change the same cycle as buffer_occupancy.
- Wrap-around: wr_ptr DEPTH−4 → 0; rd_ptr DEPTH−1 → 0. Bytes stay in order across the wrap.
- Reset, flush, or clear in mid-stream take effect at the next edge. Bytes in flight are discarded.

## Structure
- Package usb_buffer_pkg: DEPTH default, WORD_BYTES = 4, and a function for occupancy width. Shared with the transmit buffer.
- One sub-module, fifo_byte_mem: DEPTH×8 array with a 4-byte aligned write port and a 1-byte registered read port.
- Pointers, occupancy, accept logic and flags live in the top module.

## Test plan
- Reset, then write 32'h44332211 and read ×4 → rd_data 11,22,33,44 on consecutive cycles with rd_valid high; occupancy 4→0; empty 1.
- Fill with 16 writes → full 1, occupancy 64. 17th write → rejected, overflow 1, occupancy stays 64. Read all 64 → original order.
- Occupancy 60 with write + read in the same cycle → occupancy 63. At occupancy 61, write → rejected, overflow 1.
- Empty FIFO with rd_en and w_enable (32'hAABBCCDD) in the same cycle → underflow 1, rd_valid 0, occupancy 4. Next read returns DD.
- Wrap test: interleave 30 writes and 120 reads → byte sequence continuous across pointer wrap, no loss.
- occupancy 20 with overflow set, assert flush together with w_enable → occupancy 0, overflow still 1. Then assert clear → overflow 0, underflow 0. After that, rst mid-read → all reset values.

Source files
------------

// File: rtl/usb_buffer_pkg.sv
// Shared sizing constants for the USB receive/transmit byte buffers.
package usb_buffer_pkg;

  localparam int unsigned DEPTH_DEFAULT = 64;
  localparam int unsigned WORD_BYTES    = 4;

  // Occupancy must represent 0..depth inclusive, hence the extra bit.
  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_byte_mem.sv
// Byte-wide storage with a word-aligned 4-byte write port and a registered
// 1-byte read port.
module fifo_byte_mem
  import usb_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned AW    = $clog2(DEPTH),
  parameter int unsigned WAW   = AW - $clog2(WORD_BYTES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [WAW-1:0]          waddr,
  input  logic [8*WORD_BYTES-1:0] wdata,
  input  logic                    re,
  input  logic [AW-1:0]           raddr,
  output logic [7:0]              rdata
);

  localparam int unsigned BW = $clog2(WORD_BYTES);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;
  logic [7:0] rdata_d;

  // NOTE: the array carries no reset; every byte is written before it can be
  // read, and a reset here would turn the array into a large flop bank.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < int'(WORD_BYTES); i++) begin
        mem_q[{waddr, BW'(i)}] <= wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[raddr];
  end

  always_ff @(posedge clk) begin
    if (rst) rdata_q <= 8'h00;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/usb_rx_byte_fifo.sv
// Receive FIFO: 32-bit words in from the USB receiver, bytes out to the host,
// with byte occupancy, sticky overflow/underflow, flush and clear.
module usb_rx_byte_fifo
  import usb_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned OCC_W = occ_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             w_enable,
  input  logic [31:0]      rcv_data,
  input  logic             flush,
  input  logic             clear,
  input  logic             rd_en,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic [OCC_W-1:0] buffer_occupancy,
  output logic             full,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned WAW = AW - $clog2(WORD_BYTES);

  // The write pointer is kept as a word index; its byte address is
  // {wr_ptr_q, 2'b00}, so word alignment holds by construction.
  logic [WAW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;
  logic             rd_valid_q, rd_valid_d;

  logic wr_room, rd_avail, wr_acc, rd_acc;

  // Acceptance looks only at the pre-cycle occupancy.
  assign wr_room  = occ_q <= OCC_W'(DEPTH - WORD_BYTES);
  assign rd_avail = occ_q != '0;
  assign wr_acc   = w_enable && wr_room  && !clear && !flush;
  assign rd_acc   = rd_en    && rd_avail && !clear && !flush;

  // NOTE: every signal gets its hold value first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    occ_d       = occ_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    rd_valid_d  = 1'b0;
    if (clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      occ_d       = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (w_enable && !wr_room) overflow_d  = 1'b1;
      if (rd_en && !rd_avail)   underflow_d = 1'b1;
      if (wr_acc) wr_ptr_d = wr_ptr_q + WAW'(1);
      if (rd_acc) begin
        rd_ptr_d   = rd_ptr_q + AW'(1);
        rd_valid_d = 1'b1;
      end
      occ_d = occ_q + (wr_acc ? OCC_W'(WORD_BYTES) : '0) - (rd_acc ? OCC_W'(1) : '0);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its pre-edge inputs regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      rd_valid_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  fifo_byte_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (rcv_data),
    .re    (rd_acc),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  assign rd_valid         = rd_valid_q;
  assign buffer_occupancy = occ_q;
  assign full             = occ_q == OCC_W'(DEPTH);
  assign empty            = occ_q == '0;
  assign overflow         = overflow_q;
  assign underflow        = underflow_q;

endmodule

// File: tb/tb_usb_rx_byte_fifo.sv
// Directed bench for usb_rx_byte_fifo; a byte-queue reference tracks the
// expected contents, flags and read data every cycle.
module tb_usb_rx_byte_fifo;

  localparam int DEPTH = 64;
  localparam int OCC_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst, w_enable, flush, clear, rd_en;
  logic [31:0]      rcv_data;
  logic [7:0]       rd_data;
  logic             rd_valid, full, empty, overflow, underflow;
  logic [OCC_W-1:0] buffer_occupancy;

  always #5 clk = ~clk;

  usb_rx_byte_fifo #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .w_enable         (w_enable),
    .rcv_data         (rcv_data),
    .flush            (flush),
    .clear            (clear),
    .rd_en            (rd_en),
    .rd_data          (rd_data),
    .rd_valid         (rd_valid),
    .buffer_occupancy (buffer_occupancy),
    .full             (full),
    .empty            (empty),
    .overflow         (overflow),
    .underflow        (underflow)
  );

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] model_q[$];
  logic [7:0] exp_data;
  logic       exp_valid, exp_ovf, exp_unf;
  logic [7:0] next_byte = 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; w_enable = 1'b0; flush = 1'b0; clear = 1'b0; rd_en = 1'b0;
    rcv_data = 32'h0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".rd_valid"},  32'(rd_valid),         32'(exp_valid));
    check({tag, ".rd_data"},   32'(rd_data),          32'(exp_data));
    check({tag, ".occ"},       32'(buffer_occupancy), 32'(model_q.size()));
    check({tag, ".full"},      32'(full),             32'(model_q.size() == DEPTH));
    check({tag, ".empty"},     32'(empty),            32'(model_q.size() == 0));
    check({tag, ".overflow"},  32'(overflow),         32'(exp_ovf));
    check({tag, ".underflow"}, 32'(underflow),        32'(exp_unf));
  endtask

  // One clock of stimulus; the reference is updated from pre-cycle state.
  task automatic cycle(input string tag, input logic c, input logic f,
                       input logic we, input logic [31:0] word, input logic re);
    int   pre;
    logic racc, wacc;
    clear = c; flush = f; w_enable = we; rcv_data = word; rd_en = re;
    pre = model_q.size();
    exp_valid = 1'b0;
    if (c) begin
      model_q.delete();
      exp_ovf = 1'b0;
      exp_unf = 1'b0;
    end else if (f) begin
      model_q.delete();
    end else begin
      racc = re && (pre != 0);
      wacc = we && (pre + 4 <= DEPTH);
      if (we && !wacc) exp_ovf = 1'b1;
      if (re && !racc) exp_unf = 1'b1;
      if (racc) begin
        exp_data  = model_q.pop_front();
        exp_valid = 1'b1;
      end
      if (wacc) for (int b = 0; b < 4; b++) model_q.push_back(word[8*b +: 8]);
    end
    step();
    idle_inputs();
    check_outputs(tag);
  endtask

  task automatic do_reset(input string tag, input logic re);
    rst = 1'b1; rd_en = re; w_enable = re; rcv_data = 32'hDEADBEEF;
    model_q.delete();
    exp_data = 8'h00; exp_valid = 1'b0; exp_ovf = 1'b0; exp_unf = 1'b0;
    step();
    idle_inputs();
    check_outputs(tag);
  endtask

  function automatic logic [31:0] seq_word();
    logic [31:0] w;
    w = {next_byte + 8'd3, next_byte + 8'd2, next_byte + 8'd1, next_byte};
    next_byte = next_byte + 8'd4;
    return w;
  endfunction

  task automatic write_words(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag, 1'b0, 1'b0, 1'b1, seq_word(), 1'b0);
  endtask

  task automatic read_bytes(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle_inputs();
    exp_data = 8'h00; exp_valid = 1'b0; exp_ovf = 1'b0; exp_unf = 1'b0;
    rst = 1'b1;
    step();
    do_reset("reset", 1'b0);

    // Basic byte order within a word.
    cycle("wr1", 1'b0, 1'b0, 1'b1, 32'h44332211, 1'b0);
    cycle("rd_b0", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("rd_b0.value", 32'(rd_data), 32'h11);
    cycle("rd_b1", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("rd_b1.value", 32'(rd_data), 32'h22);
    cycle("rd_b2", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("rd_b2.value", 32'(rd_data), 32'h33);
    cycle("rd_b3", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("rd_b3.value", 32'(rd_data), 32'h44);
    check("rd_b3.empty", 32'(empty), 32'd1);

    // Fill to full, reject one more, drain in order.
    write_words("fill", 16);
    check("fill.full", 32'(full), 32'd1);
    check("fill.occ64", 32'(buffer_occupancy), 32'd64);
    cycle("wr17", 1'b0, 1'b0, 1'b1, 32'hCAFEF00D, 1'b0);
    check("wr17.overflow", 32'(overflow), 32'd1);
    read_bytes("drain64", 64);

    // Simultaneous write+read nets +3; 61 has no room for a word.
    cycle("clr1", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    write_words("fill60", 15);
    cycle("wr_rd60", 1'b0, 1'b0, 1'b1, seq_word(), 1'b1);
    check("wr_rd60.occ63", 32'(buffer_occupancy), 32'd63);
    read_bytes("to61", 2);
    cycle("wr61", 1'b0, 1'b0, 1'b1, 32'h12345678, 1'b0);
    check("wr61.occ61", 32'(buffer_occupancy), 32'd61);
    check("wr61.overflow", 32'(overflow), 32'd1);
    read_bytes("drain61", 61);

    // Read on empty is not satisfied by a same-cycle write.
    cycle("rdwr_empty", 1'b0, 1'b0, 1'b1, 32'hAABBCCDD, 1'b1);
    check("rdwr_empty.valid", 32'(rd_valid), 32'd0);
    check("rdwr_empty.occ4", 32'(buffer_occupancy), 32'd4);
    cycle("rd_dd", 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    check("rd_dd.value", 32'(rd_data), 32'hDD);
    read_bytes("drain_aabbcc", 3);

    // Pointer wrap: 30 words streamed through with continuous reads.
    write_words("wrap_pre", 1);
    for (int g = 0; g < 30; g++) begin
      cycle("wrap_wr", 1'b0, 1'b0, 1'b1, seq_word(), 1'b1);
      read_bytes("wrap_rd", 3);
    end
    read_bytes("wrap_tail", 4);

    // Flush keeps error flags; clear drops them; reset mid-read.
    write_words("fill20", 5);
    check("fill20.occ", 32'(buffer_occupancy), 32'd20);
    cycle("flush", 1'b0, 1'b1, 1'b1, 32'h99999999, 1'b1);
    check("flush.occ0", 32'(buffer_occupancy), 32'd0);
    check("flush.overflow", 32'(overflow), 32'd1);
    cycle("clear", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    check("clear.overflow", 32'(overflow), 32'd0);
    check("clear.underflow", 32'(underflow), 32'd0);
    write_words("pre_rst", 2);
    read_bytes("pre_rst_rd", 1);
    do_reset("rst_mid", 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
